// File: rtl/vending_dispenser_pkg.sv
// Shared types and constants for the vending machine dispense back end.
// Slot indices double as motor bit positions and restock selectors.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SPIN      = 2'd1,
    WAIT_DROP = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam logic [1:0] SLOT_SNACK  = 2'd0;
  localparam logic [1:0] SLOT_COFFEE = 2'd1;
  localparam logic [1:0] SLOT_DRINK  = 2'd2;
  localparam logic [1:0] SLOT_CANDY  = 2'd3;

  localparam int unsigned STOCK_W = 3;
  localparam logic [STOCK_W-1:0] STOCK_MAX = 3'd7;

  // Sum one bit wider than a count so an overflow can be clamped to STOCK_MAX
  function automatic logic [STOCK_W-1:0] stock_sat_add(input logic [STOCK_W-1:0] count,
                                                       input logic [STOCK_W-1:0] qty);
    logic [STOCK_W:0] sum;
    sum = {1'b0, count} + {1'b0, qty};
    return (sum > {1'b0, STOCK_MAX}) ? STOCK_MAX : sum[STOCK_W-1:0];
  endfunction

  function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
    return 4'b0001 << slot;
  endfunction

endpackage

// File: rtl/vending_dispenser_if.sv
// Controller-facing bundle of the dispenser: dispense pulses, drop sensor,
// restock handshake and the registered status outputs.
interface vending_dispenser_if;
  import vending_pkg::*;

  logic               product_snack;
  logic               product_coffee;
  logic               product_drink;
  logic               product_candy;
  logic               drop_sensor;
  logic               restock_valid;
  logic [1:0]         restock_sel;
  logic [STOCK_W-1:0] restock_qty;
  logic               restock_ready;
  logic [STOCK_W-1:0] snack;
  logic [STOCK_W-1:0] coffee;
  logic [STOCK_W-1:0] drink;
  logic [STOCK_W-1:0] candy;
  logic [3:0]         motor;
  logic               busy;
  logic               no_product;

  modport master (
    output product_snack, product_coffee, product_drink, product_candy,
    output drop_sensor, restock_valid, restock_sel, restock_qty,
    input  restock_ready, snack, coffee, drink, candy, motor, busy, no_product
  );

  modport slave (
    input  product_snack, product_coffee, product_drink, product_candy,
    input  drop_sensor, restock_valid, restock_sel, restock_qty,
    output restock_ready, snack, coffee, drink, candy, motor, busy, no_product
  );

endinterface

// File: rtl/vending_dispenser_timer.sv
// Loadable down-counter shared by the motor-on and drop-wait phases.
// done is high while the count sits at zero; load wins over enable.
module dispense_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/vending_dispenser.sv
// Dispense-side back end: drives one slot motor per request, confirms the drop,
// keeps per-slot stock counts, latches a sticky jam fault and accepts restocks.
module vending_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned MOTOR_CYCLES = 8,
  parameter int unsigned DROP_TIMEOUT = 16,
  parameter int unsigned INIT_STOCK   = 0
) (
  input  logic          clk,
  input  logic          rst,
  vending_dispenser_if.slave bus
);

  localparam int unsigned TIMER_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

  // The timer counts down to zero inclusive, so load one less than the phase length
  localparam logic [TIMER_W-1:0] SPIN_LOAD = TIMER_W'(MOTOR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(DROP_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [3:0]         motor_q, motor_d;
  logic               busy_q, busy_d;
  logic               no_product_q, no_product_d;
  logic [STOCK_W-1:0] stock_q [4];
  logic [STOCK_W-1:0] stock_d [4];

  logic               any_req;
  logic [1:0]         req_slot;
  logic               tmr_load;
  logic               tmr_en;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_done;

  dispense_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .enable     (tmr_en),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  assign any_req = bus.product_snack | bus.product_coffee | bus.product_drink | bus.product_candy;

  always_comb begin
    req_slot = SLOT_CANDY;
    if (bus.product_snack) begin
      req_slot = SLOT_SNACK;
    end else if (bus.product_coffee) begin
      req_slot = SLOT_COFFEE;
    end else if (bus.product_drink) begin
      req_slot = SLOT_DRINK;
    end
  end

  // A dispense request in IDLE blocks the restock handshake for that cycle
  assign bus.restock_ready = (state_q == IDLE) && !any_req;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    motor_d      = motor_q;
    busy_d       = busy_q;
    no_product_d = no_product_q;
    stock_d      = stock_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_value    = SPIN_LOAD;

    case (state_q)
      IDLE: begin
        motor_d = 4'b0000;
        busy_d  = 1'b0;
        if (any_req) begin
          if (stock_q[req_slot] != '0) begin
            state_d  = SPIN;
            slot_d   = req_slot;
            motor_d  = slot_onehot(req_slot);
            busy_d   = 1'b1;
            tmr_load = 1'b1;
          end
        end else if (bus.restock_valid) begin
          stock_d[bus.restock_sel] = stock_sat_add(stock_q[bus.restock_sel], bus.restock_qty);
        end
      end

      SPIN: begin
        tmr_en = 1'b1;
        if (bus.drop_sensor) begin
          state_d         = IDLE;
          motor_d         = 4'b0000;
          busy_d          = 1'b0;
          stock_d[slot_q] = stock_q[slot_q] - STOCK_W'(1);
        end else if (tmr_done) begin
          state_d   = WAIT_DROP;
          motor_d   = 4'b0000;
          tmr_load  = 1'b1;
          tmr_value = WAIT_LOAD;
        end
      end

      WAIT_DROP: begin
        tmr_en  = 1'b1;
        motor_d = 4'b0000;
        if (bus.drop_sensor) begin
          state_d         = IDLE;
          busy_d          = 1'b0;
          stock_d[slot_q] = stock_q[slot_q] - STOCK_W'(1);
        end else if (tmr_done) begin
          state_d      = FAULT;
          busy_d       = 1'b0;
          no_product_d = 1'b1;
        end
      end

      FAULT: begin
        motor_d      = 4'b0000;
        busy_d       = 1'b0;
        no_product_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        motor_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= SLOT_SNACK;
      motor_q      <= 4'b0000;
      busy_q       <= 1'b0;
      no_product_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      motor_q      <= motor_d;
      busy_q       <= busy_d;
      no_product_q <= no_product_d;
      stock_q      <= stock_d;
    end
  end

  assign bus.motor      = motor_q;
  assign bus.busy       = busy_q;
  assign bus.no_product = no_product_q;
  assign bus.snack      = stock_q[SLOT_SNACK];
  assign bus.coffee     = stock_q[SLOT_COFFEE];
  assign bus.drink      = stock_q[SLOT_DRINK];
  assign bus.candy      = stock_q[SLOT_CANDY];

endmodule

// File: tb/tb_vending_dispenser.sv
// Directed self-checking bench for vending_dispenser with default parameters
// (MOTOR_CYCLES=8, DROP_TIMEOUT=16, INIT_STOCK=0).
module tb_vending_dispenser;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  vending_dispenser_if bus ();

  vending_dispenser #(
    .MOTOR_CYCLES (8),
    .DROP_TIMEOUT (16),
    .INIT_STOCK   (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic snack, input logic coffee, input logic drink,
                               input logic candy, input logic drop, input logic rv,
                               input logic [1:0] sel, input logic [2:0] qty);
    bus.product_snack  = snack;
    bus.product_coffee = coffee;
    bus.product_drink  = drink;
    bus.product_candy  = candy;
    bus.drop_sensor    = drop;
    bus.restock_valid  = rv;
    bus.restock_sel    = sel;
    bus.restock_qty    = qty;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are checked at the falling edge
  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 2'd0, 3'd0);
  endtask

  task automatic restock(input logic [1:0] sel, input logic [2:0] qty);
    applyStimulus(0, 0, 0, 0, 0, 1, sel, qty);
    cycle(1);
    idleInputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    idleInputs();
    cycle(2);
    rst = 1'b0;

    checkOutput("rst_motor", bus.motor, 4'b0000);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_no_product", bus.no_product, 1'b0);
    checkOutput("rst_counts", {bus.snack, bus.coffee, bus.drink, bus.candy}, 12'h000);
    #1 checkOutput("rst_ready", bus.restock_ready, 1'b1);

    // Restock snack 5
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd0, 3'd5);
    #1 checkOutput("rs_ready", bus.restock_ready, 1'b1);
    cycle(1);
    idleInputs();
    checkOutput("rs_snack5", bus.snack, 3'd5);
    checkOutput("rs_others0", {bus.coffee, bus.drink, bus.candy}, 9'h000);

    // Saturation 6 + 4 -> 7, then drink + 0
    restock(2'd1, 3'd6);
    checkOutput("rs_coffee6", bus.coffee, 3'd6);
    restock(2'd1, 3'd4);
    checkOutput("rs_coffee_sat", bus.coffee, 3'd7);
    restock(2'd2, 3'd0);
    checkOutput("rs_drink0", bus.drink, 3'd0);

    // Fresh stock: snack 1, coffee 3, drink 2, candy 1
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    checkOutput("rst2_counts", {bus.snack, bus.coffee, bus.drink, bus.candy}, 12'h000);
    restock(2'd0, 3'd1);
    restock(2'd1, 3'd3);
    restock(2'd2, 3'd2);
    restock(2'd3, 3'd1);
    checkOutput("setup_counts", {bus.snack, bus.coffee, bus.drink, bus.candy}, {3'd1, 3'd3, 3'd2, 3'd1});

    // Coffee dispense, drop in the 3rd motor cycle
    applyStimulus(0, 1, 0, 0, 0, 0, 2'd0, 3'd0);
    cycle(1);
    idleInputs();
    checkOutput("cof_motor_c1", bus.motor, 4'b0010);
    checkOutput("cof_busy_c1", bus.busy, 1'b1);
    cycle(1);
    checkOutput("cof_motor_c2", bus.motor, 4'b0010);
    cycle(1);
    checkOutput("cof_motor_c3", bus.motor, 4'b0010);
    applyStimulus(0, 0, 0, 0, 1, 0, 2'd0, 3'd0);
    cycle(1);
    idleInputs();
    checkOutput("cof_motor_off", bus.motor, 4'b0000);
    checkOutput("cof_busy_off", bus.busy, 1'b0);
    checkOutput("cof_count", bus.coffee, 3'd2);
    #1 checkOutput("cof_ready", bus.restock_ready, 1'b1);

    // Drink dispense with no drop -> jam after 8 + 16 cycles
    applyStimulus(0, 0, 1, 0, 0, 0, 2'd0, 3'd0);
    cycle(1);
    idleInputs();
    checkOutput("jam_motor_c1", bus.motor, 4'b0100);
    cycle(7);
    checkOutput("jam_motor_c8", bus.motor, 4'b0100);
    cycle(1);
    checkOutput("jam_wait_motor", bus.motor, 4'b0000);
    checkOutput("jam_wait_busy", bus.busy, 1'b1);
    cycle(15);
    checkOutput("jam_not_yet", bus.no_product, 1'b0);
    cycle(1);
    checkOutput("jam_no_product", bus.no_product, 1'b1);
    checkOutput("jam_busy", bus.busy, 1'b0);
    checkOutput("jam_drink", bus.drink, 3'd2);

    // FAULT ignores requests and restocks
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd0, 3'd0);
    cycle(1);
    idleInputs();
    checkOutput("flt_motor", bus.motor, 4'b0000);
    checkOutput("flt_snack", bus.snack, 3'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd3, 3'd2);
    #1 checkOutput("flt_ready", bus.restock_ready, 1'b0);
    cycle(1);
    idleInputs();
    checkOutput("flt_candy", bus.candy, 3'd1);
    checkOutput("flt_sticky", bus.no_product, 1'b1);

    // Reset leaves FAULT; stock snack 1, candy 1
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    checkOutput("flt_rst_no_product", bus.no_product, 1'b0);
    restock(2'd0, 3'd1);
    restock(2'd3, 3'd1);

    // Simultaneous snack, candy and restock: snack wins, restock held
    applyStimulus(1, 0, 0, 1, 0, 1, 2'd3, 3'd2);
    #1 checkOutput("pri_ready_req", bus.restock_ready, 1'b0);
    cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd3, 3'd2);
    checkOutput("pri_motor", bus.motor, 4'b0001);
    #1 checkOutput("pri_ready_spin", bus.restock_ready, 1'b0);
    applyStimulus(0, 0, 0, 0, 1, 1, 2'd3, 3'd2);
    cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd3, 3'd2);
    checkOutput("pri_snack0", bus.snack, 3'd0);
    checkOutput("pri_candy_held", bus.candy, 3'd1);
    #1 checkOutput("pri_ready_idle", bus.restock_ready, 1'b1);
    cycle(1);
    idleInputs();
    checkOutput("pri_candy3", bus.candy, 3'd3);

    // Zero-stock request is ignored
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd0, 3'd0);
    cycle(1);
    idleInputs();
    checkOutput("zero_busy", bus.busy, 1'b0);
    checkOutput("zero_motor", bus.motor, 4'b0000);

    // Reset during the 4th SPIN cycle
    applyStimulus(0, 0, 0, 1, 0, 0, 2'd0, 3'd0);
    cycle(1);
    idleInputs();
    cycle(3);
    checkOutput("rspin_motor_c4", bus.motor, 4'b1000);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    checkOutput("rspin_motor", bus.motor, 4'b0000);
    checkOutput("rspin_busy", bus.busy, 1'b0);
    checkOutput("rspin_counts", {bus.snack, bus.coffee, bus.drink, bus.candy}, 12'h000);

    // Normal dispense after reset, drop during WAIT_DROP
    restock(2'd2, 3'd1);
    applyStimulus(0, 0, 1, 0, 0, 0, 2'd0, 3'd0);
    cycle(1);
    idleInputs();
    checkOutput("post_motor", bus.motor, 4'b0100);
    cycle(8);
    checkOutput("post_wait_busy", bus.busy, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 0, 2'd0, 3'd0);
    cycle(1);
    idleInputs();
    checkOutput("post_busy", bus.busy, 1'b0);
    checkOutput("post_drink", bus.drink, 3'd0);
    checkOutput("post_no_product", bus.no_product, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_dispenser.md
# vending_dispenser

Dispense-side back end of the vending machine. It consumes the controller's one-cycle `product_*` delivery pulses and drives the matching slot motor. It confirms each drop on the optical sensor and keeps the per-slot stock counts that the controller reads as `snack/coffee/drink/candy`. It raises `no_product` on a dispense jam and accepts restock transactions through a valid/ready handshake.

## Interface
- `MOTOR_CYCLES`, default 8: cycles the motor is driven per dispense (≥1).
- `DROP_TIMEOUT`, default 16: cycles allowed after motor-off for a drop before a jam is declared (≥1).
- `INIT_STOCK`, default 0: stock loaded into every slot on reset (0..7).
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `product_snack`, `product_coffee`, `product_drink`, `product_candy`  in  1 each  one-cycle dispense requests from the controller.
- `drop_sensor`  in  1  high while an item falls; already synchronised.
- `restock_valid`  in  1  restock request.
- `restock_sel`  in  2  slot to restock: 0 snack, 1 coffee, 2 drink, 3 candy.
- `restock_qty`  in  3  items added.
- `restock_ready`  out  1  restock accepted when high together with `restock_valid`.
- `snack`, `coffee`, `drink`, `candy`  out  3 each  stock counts, 0..7.
- `motor`  out  4  one-hot motor drive, bit index = slot index.
- `busy`  out  1  dispense in progress.
- `no_product`  out  1  sticky jam fault.

## Operation
- FSM states:
  - IDLE: wait for a request or restock.
  - SPIN: motor on.
  - WAIT_DROP: motor off, waiting for the sensor.
  - FAULT: terminal.
- IDLE, any `product_*` high:
  - Priority snack > coffee > drink > candy; the other simultaneous pulses are dropped.
  - If the chosen slot count is 0, the request is ignored and the FSM stays in IDLE.
  - Otherwise the slot is latched and the FSM goes to SPIN.
- SPIN:
  - `motor[slot]`=1 for MOTOR_CYCLES cycles, then WAIT_DROP.
  - `drop_sensor` high in SPIN counts as success: motor off, decrement, IDLE.
- WAIT_DROP:
  - `drop_sensor` high → decrement the slot count, go to IDLE.
  - DROP_TIMEOUT cycles elapse with no drop → FAULT, count unchanged.
- FAULT:
  - `no_product`=1, motor off, `busy`=0, `restock_ready`=0.
  - All requests are ignored; only `rst` exits.
- `product_*` pulses in SPIN or WAIT_DROP are ignored; they are not queued.
- Restock:
  - `restock_ready` = IDLE and no `product_*` high this cycle; a dispense request wins over a restock in the same cycle.
  - On `restock_valid && restock_ready`: count[sel] ← min(count + qty, 7).
  - The addition is done 4 bits wide, then saturated to 3 bits.
  - Once asserted, `restock_valid` must stay high with stable sel/qty until accepted.
- The decrement never underflows, because zero-stock requests never leave IDLE.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `motor`=0, `busy`=0, `no_product`=0.
  - All counts = INIT_STOCK; FSM in IDLE, so `restock_ready`=1.
- `rst` high in any state, including SPIN or FAULT, fully overrides it: motor drops on the next edge.
- Request sampled at edge N:
  - `motor[slot]` and `busy` go high after edge N.
  - The motor stays high for exactly MOTOR_CYCLES cycles.
- Drop sampled at edge M:
  - Motor is 0, `busy` is 0 and the count is decremented after edge M.
  - A new request is accepted at edge M+1.
- Restock accepted at edge K: the count is updated after edge K.
- Jam: `no_product` rises after the edge that samples the DROP_TIMEOUT-th cycle of WAIT_DROP with no drop.
- All outputs are registered except `restock_ready`, which is decoded from state and the inputs.

## Structure
- `vending_pkg` holds:
  - the state enum (IDLE/SPIN/WAIT_DROP/FAULT);
  - the slot index constants SLOT_SNACK=0, SLOT_COFFEE=1, SLOT_DRINK=2, SLOT_CANDY=3;
  - STOCK_MAX=7 and STOCK_W=3.
- Sub-module `dispense_timer`: a loadable down-counter of width `$clog2(max(MOTOR_CYCLES,DROP_TIMEOUT)+1)` with load, enable and `done` signals.
- `vending_dispenser` uses `dispense_timer` once, reloading it on SPIN entry and on WAIT_DROP entry.

## Test plan
- Reset with INIT_STOCK=0, then restock snack qty 5 → `restock_ready`=1 and `snack`=5 the cycle after the handshake; all other counts stay 0.
- Restock coffee 6, then coffee 4 → `coffee`=7 (saturated); a following restock of drink 0 → `drink`=0.
- `coffee`=3, pulse `product_coffee`, `drop_sensor` high in the 3rd motor cycle → `motor`=4'b0010 for 3 cycles, then `coffee`=2 and `busy`=0.
- `drink`=2, pulse `product_drink`, no drop → after 8+16 cycles `no_product`=1 and `drink`=2; a later `product_snack` and `restock_valid` are both ignored until `rst`.
- IDLE with `snack`=1 and `candy`=1: `product_snack`, `product_candy` and `restock_valid` (candy, 2) all high together → only snack is dispensed and `restock_ready`=0 that cycle. The held restock is accepted the first IDLE cycle after the drop, giving `candy`=3 and `snack`=0.
- `rst` asserted in the 4th SPIN cycle → `motor`=0, `busy`=0 and all counts = INIT_STOCK the next cycle; a normal dispense then succeeds.
